// File: rtl/ex_pkg.sv
// rtl/ex_pkg.sv - shared widths, bundle field positions and ALU opcodes for the execute stage
package ex_pkg;

    localparam int XLEN       = 64;
    localparam int REG_ADDR_W = 5;
    localparam int ID_EX_W    = 176;
    localparam int EX_WB_W    = 71;

    // ID/EX bundle field positions
    localparam int IDX_OP_A_LSB   = 112;
    localparam int IDX_OP_B_LSB   = 48;
    localparam int IDX_IMM_LSB    = 16;
    localparam int IDX_RD_LSB     = 11;
    localparam int IDX_ALU_OP_LSB = 6;
    localparam int IDX_USE_IMM    = 5;
    localparam int IDX_WORD       = 4;
    localparam int IDX_REG_WRITE  = 3;
    localparam int IDX_VALID      = 2;

    // EX/WB bundle field positions
    localparam int WB_RESULT_LSB = 7;
    localparam int WB_RD_LSB     = 2;
    localparam int WB_REG_WRITE  = 1;
    localparam int WB_VALID      = 0;

    typedef enum logic [4:0] {
        ALU_ADD   = 5'd0,
        ALU_SUB   = 5'd1,
        ALU_AND   = 5'd2,
        ALU_OR    = 5'd3,
        ALU_XOR   = 5'd4,
        ALU_SLL   = 5'd5,
        ALU_SRL   = 5'd6,
        ALU_SRA   = 5'd7,
        ALU_SLT   = 5'd8,
        ALU_SLTU  = 5'd9,
        ALU_PASSB = 5'd10
    } alu_op_e;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

endpackage

// File: rtl/alu64.sv
// rtl/alu64.sv - combinational 64-bit integer ALU with 32-bit word variants
module alu64
    import ex_pkg::*;
(
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [4:0]      alu_op,
    input  logic            word,
    output logic [XLEN-1:0] result,
    output logic            legal
);

    logic [5:0]  shamt;
    logic [31:0] r32;

    // Word ops only honour the low five shift bits
    assign shamt = word ? {1'b0, b[4:0]} : b[5:0];

    // Operation select; word only matters for add/sub/shifts
    always_comb begin
        result = '0;
        legal  = 1'b1;
        r32    = '0;
        case (alu_op)
            ALU_ADD: begin
                r32    = a[31:0] + b[31:0];
                result = word ? sext32(r32) : a + b;
            end
            ALU_SUB: begin
                r32    = a[31:0] - b[31:0];
                result = word ? sext32(r32) : a - b;
            end
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_SLL: begin
                r32    = a[31:0] << shamt[4:0];
                result = word ? sext32(r32) : a << shamt;
            end
            ALU_SRL: begin
                r32    = a[31:0] >> shamt[4:0];
                result = word ? sext32(r32) : a >> shamt;
            end
            ALU_SRA: begin
                r32    = $unsigned($signed(a[31:0]) >>> shamt[4:0]);
                result = word ? sext32(r32) : $unsigned($signed(a) >>> shamt);
            end
            ALU_SLT:   result = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_SLTU:  result = {{(XLEN-1){1'b0}}, a < b};
            ALU_PASSB: result = b;
            default: begin
                result = '0;
                legal  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - execute stage: operand select, ALU, bubble/illegal masking, EX/WB register
module execute_stage
    import ex_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic [ID_EX_W-1:0] ID_EX,
    output logic [EX_WB_W-1:0] EX_WB
);

    logic [XLEN-1:0]       op_a;
    logic [XLEN-1:0]       op_b;
    logic [31:0]           imm32;
    logic [REG_ADDR_W-1:0] rd;
    logic [4:0]            alu_op;
    logic                  use_imm;
    logic                  word;
    logic                  reg_write;
    logic                  valid;
    logic [1:0]            unused_reserved;

    logic [XLEN-1:0] operand_b;
    logic [XLEN-1:0] alu_result;
    logic            alu_legal;

    assign op_a            = ID_EX[IDX_OP_A_LSB +: XLEN];
    assign op_b            = ID_EX[IDX_OP_B_LSB +: XLEN];
    assign imm32           = ID_EX[IDX_IMM_LSB +: 32];
    assign rd              = ID_EX[IDX_RD_LSB +: REG_ADDR_W];
    assign alu_op          = ID_EX[IDX_ALU_OP_LSB +: 5];
    assign use_imm         = ID_EX[IDX_USE_IMM];
    assign word            = ID_EX[IDX_WORD];
    assign reg_write       = ID_EX[IDX_REG_WRITE];
    assign valid           = ID_EX[IDX_VALID];
    assign unused_reserved = ID_EX[1:0];

    assign operand_b = use_imm ? sext32(imm32) : op_b;

    alu64 u_alu (
        .a      (op_a),
        .b      (operand_b),
        .alu_op (alu_op),
        .word   (word),
        .result (alu_result),
        .legal  (alu_legal)
    );

    // Register the writeback bundle; bubbles and reset clear it entirely
    always_ff @(posedge clock) begin
        if (reset) begin
            EX_WB <= '0;
        end else if (!valid) begin
            EX_WB <= '0;
        end else begin
            EX_WB <= {alu_legal ? alu_result : {XLEN{1'b0}},
                      rd,
                      reg_write & alu_legal,
                      1'b1};
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// tb/tb_execute_stage.sv - directed self-checking bench for execute_stage
module tb_execute_stage;

    logic         clock;
    logic         reset;
    logic [175:0] ID_EX;
    logic [70:0]  EX_WB;

    int total = 0;
    int bad   = 0;

    execute_stage dut (
        .clock (clock),
        .reset (reset),
        .ID_EX (ID_EX),
        .EX_WB (EX_WB)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [175:0] mk(input logic [63:0] op_a, input logic [63:0] op_b,
                                        input logic [31:0] imm, input logic [4:0] rd,
                                        input logic [4:0] op, input logic use_imm,
                                        input logic word, input logic rw, input logic v);
        return {op_a, op_b, imm, rd, op, use_imm, word, rw, v, 2'b00};
    endfunction

    function automatic logic [70:0] wb(input logic [63:0] res, input logic [4:0] rd,
                                       input logic rw, input logic v);
        return {res, rd, rw, v};
    endfunction

    task automatic check(input string tag, input logic [70:0] got, input logic [70:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Drive at negedge, let one rising edge pass, sample at the following negedge
    task automatic step(input logic [175:0] bundle);
        ID_EX = bundle;
        @(posedge clock);
        @(negedge clock);
    endtask

    logic [175:0] tmp;

    initial begin
        reset = 1'b1;
        ID_EX = mk(64'h1234, 64'h5678, 32'h9, 5'd7, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge clock);
        step(ID_EX);
        step(ID_EX);
        check("reset_hold", EX_WB, 71'h0);

        // Low 64 bits all ones: alu_op=31 illegal, valid, rd=31
        tmp = '0;
        tmp[63:0] = 64'hFFFF_FFFF_FFFF_FFFF;
        step(tmp);
        check("reset_allones", EX_WB, 71'h0);
        reset = 1'b0;
        step(tmp);
        check("illegal_allones", EX_WB, 71'h7D);

        step(mk(64'h10, 64'h0, 32'hFFFF_FFFE, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1));
        check("add_imm", EX_WB, wb(64'hE, 5'd5, 1'b1, 1'b1));

        step(mk(64'h0, 64'h1, 32'h0, 5'd1, 5'd1, 1'b0, 1'b1, 1'b1, 1'b1));
        check("subw", EX_WB, wb(64'hFFFF_FFFF_FFFF_FFFF, 5'd1, 1'b1, 1'b1));

        step(mk(64'h8000_0000, 64'h1, 32'h0, 5'd2, 5'd6, 1'b0, 1'b1, 1'b1, 1'b1));
        check("srlw", EX_WB, wb(64'h4000_0000, 5'd2, 1'b1, 1'b1));

        step(mk(64'hFFFF_FFFF_8000_0000, 64'h1, 32'h0, 5'd2, 5'd6, 1'b0, 1'b1, 1'b1, 1'b1));
        check("srlw_hi_ignored", EX_WB, wb(64'h4000_0000, 5'd2, 1'b1, 1'b1));

        step(mk(64'h0000_0000_8000_0000, 64'h1, 32'h0, 5'd2, 5'd7, 1'b0, 1'b1, 1'b1, 1'b1));
        check("sraw", EX_WB, wb(64'hFFFF_FFFF_C000_0000, 5'd2, 1'b1, 1'b1));

        step(mk(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 32'h0, 5'd3, 5'd8, 1'b0, 1'b0, 1'b1, 1'b1));
        check("slt", EX_WB, wb(64'h1, 5'd3, 1'b1, 1'b1));

        step(mk(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 32'h0, 5'd3, 5'd9, 1'b0, 1'b0, 1'b1, 1'b1));
        check("sltu", EX_WB, wb(64'h0, 5'd3, 1'b1, 1'b1));

        step(mk(64'h8000_0000_0000_0000, 64'd63, 32'h0, 5'd4, 5'd7, 1'b0, 1'b0, 1'b1, 1'b1));
        check("sra64", EX_WB, wb(64'hFFFF_FFFF_FFFF_FFFF, 5'd4, 1'b1, 1'b1));

        step(mk(64'h1, 64'h41, 32'h0, 5'd6, 5'd5, 1'b0, 1'b0, 1'b1, 1'b1));
        check("sll_mask6", EX_WB, wb(64'h2, 5'd6, 1'b1, 1'b1));

        step(mk(64'h1, 64'd31, 32'h0, 5'd6, 5'd5, 1'b0, 1'b1, 1'b1, 1'b1));
        check("sllw", EX_WB, wb(64'hFFFF_FFFF_8000_0000, 5'd6, 1'b1, 1'b1));

        step(mk(64'h7FFF_FFFF, 64'h1, 32'h0, 5'd7, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1));
        check("addw_ovf", EX_WB, wb(64'hFFFF_FFFF_8000_0000, 5'd7, 1'b1, 1'b1));

        step(mk(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 32'h0, 5'd7, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1));
        check("add64_wrap", EX_WB, wb(64'h0, 5'd7, 1'b1, 1'b1));

        step(mk(64'hF0F0, 64'hFF00, 32'h0, 5'd8, 5'd2, 1'b0, 1'b0, 1'b1, 1'b1));
        check("and", EX_WB, wb(64'hF000, 5'd8, 1'b1, 1'b1));
        step(mk(64'hF0F0, 64'hFF00, 32'h0, 5'd8, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1));
        check("or", EX_WB, wb(64'hFFF0, 5'd8, 1'b1, 1'b1));
        step(mk(64'hF0F0, 64'hFF00, 32'h0, 5'd8, 5'd4, 1'b0, 1'b0, 1'b1, 1'b1));
        check("xor", EX_WB, wb(64'h0FF0, 5'd8, 1'b1, 1'b1));

        step(mk(64'hFFFF_0000_0000_0001, 64'hFFFF_0000_0000_0003, 32'h0, 5'd9, 5'd2, 1'b0, 1'b1, 1'b1, 1'b1));
        check("and_word_ignored", EX_WB, wb(64'hFFFF_0000_0000_0001, 5'd9, 1'b1, 1'b1));

        step(mk(64'h0, 64'h1234, 32'h8000_0000, 5'd10, 5'd10, 1'b1, 1'b0, 1'b1, 1'b1));
        check("passb_imm", EX_WB, wb(64'hFFFF_FFFF_8000_0000, 5'd10, 1'b1, 1'b1));

        step(mk(64'h5, 64'h6, 32'h0, 5'd11, 5'd11, 1'b0, 1'b0, 1'b1, 1'b1));
        check("illegal11", EX_WB, wb(64'h0, 5'd11, 1'b0, 1'b1));

        step(mk(64'h5, 64'h6, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1));
        check("rw0_rd0", EX_WB, wb(64'hB, 5'd0, 1'b0, 1'b1));

        tmp = mk(64'h5, 64'h6, 32'h0, 5'd12, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        tmp[1:0] = 2'b11;
        step(tmp);
        check("reserved_bits", EX_WB, wb(64'hB, 5'd12, 1'b1, 1'b1));

        step(mk(64'hDEAD, 64'hBEEF, 32'h1, 5'd13, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0));
        check("bubble", EX_WB, 71'h0);

        // Alternate valid and bubble every cycle
        for (int i = 0; i < 6; i++) begin
            step(mk(64'(i), 64'd100, 32'h0, 5'(i + 1), 5'd0, 1'b0, 1'b0, 1'b1, (i % 2) == 0));
            if ((i % 2) == 0)
                check($sformatf("alt_valid_%0d", i), EX_WB, wb(64'(100 + i), 5'(i + 1), 1'b1, 1'b1));
            else
                check($sformatf("alt_bubble_%0d", i), EX_WB, 71'h0);
        end

        // Reset mid-stream drops the in-flight bundle
        step(mk(64'h1, 64'h2, 32'h0, 5'd14, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1));
        check("pre_reset", EX_WB, wb(64'h3, 5'd14, 1'b1, 1'b1));
        reset = 1'b1;
        step(mk(64'h3, 64'h4, 32'h0, 5'd15, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1));
        check("mid_reset", EX_WB, 71'h0);
        reset = 1'b0;
        step(mk(64'h10, 64'h20, 32'h0, 5'd16, 5'd1, 1'b0, 1'b0, 1'b1, 1'b1));
        check("post_reset", EX_WB, wb(64'hFFFF_FFFF_FFFF_FFF0, 5'd16, 1'b1, 1'b1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
